// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake between a requester and the UART transmitter.
interface uart_tx_ctrl_if;
   logic [7:0] din;
   logic       din_valid;
   logic       din_ready;

   // Requester side: offers bytes, observes ready.
   modport master (output din, output din_valid, input din_ready);
   // Transmitter side: consumes bytes, reports ready.
   modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: 8 data bits, no parity, 1 or 2 stop bits, LSB first.
module uart_tx_ctrl #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   uart_tx_ctrl_if.slave   bus,
   output logic            tx,
   output logic            busy,
   output logic            done
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       idx;
   logic             stop_cnt;
   logic [7:0]       shift_reg;
   logic             bit_end;
   logic             accept;

   // Handshake and bit-period decode.
   assign bus.din_ready = (state == IDLE) && en;
   assign accept        = bus.din_valid && bus.din_ready;
   assign bit_end       = (cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign busy          = (state != IDLE);

   // Frame sequencer; everything freezes while en is low, and done only survives one enabled cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         stop_cnt  <= 1'b0;
         shift_reg <= '0;
         tx        <= 1'b1;
         done      <= 1'b0;
      end else if (en) begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  shift_reg <= bus.din;
                  cnt       <= '0;
                  idx       <= '0;
                  stop_cnt  <= 1'b0;
                  tx        <= 1'b0;
                  state     <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  cnt   <= '0;
                  idx   <= '0;
                  tx    <= shift_reg[0];
                  state <= DATA;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt       <= '0;
                  shift_reg <= {1'b0, shift_reg[7:1]};
                  idx       <= idx + 3'd1;
                  if (idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     tx <= shift_reg[1];
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            STOP: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (stop_cnt == 1'(STOP_BITS - 1)) begin
                     stop_cnt <= 1'b0;
                     done     <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     stop_cnt <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end else begin
         done <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomised scoreboard bench for uart_tx_ctrl, one DUT per stop-bit setting.
module tb_uart_tx_ctrl;

   localparam int unsigned CPB = 4;

   typedef struct packed {
      logic tx;
      logic busy;
      logic done;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [7:0] din = 8'h00;
   logic       din_valid = 1'b0;

   // Inputs as seen by the most recent rising edge.
   logic       pe_rst = 1'b0;
   logic       pe_en = 1'b0;
   logic       pe_valid = 1'b0;
   logic [7:0] pe_din = 8'h00;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic exp_t mk(logic t, logic b, logic d);
      exp_t e;
      e.tx = t;
      e.busy = b;
      e.done = d;
      return e;
   endfunction

   function automatic void chk(string name, int sb, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s stop_bits=%0d t=%0t actual=%0h expected=%0h", name, sb, $time, act, exp);
      end
   endfunction

   always @(posedge clk) begin
      pe_rst   = rst_n;
      pe_en    = en;
      pe_valid = din_valid;
      pe_din   = din;
   end

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int unsigned SB = g + 1;

      uart_tx_ctrl_if u_if ();
      logic tx_o;
      logic busy_o;
      logic done_o;
      exp_t q[$];
      exp_t last = 3'b100;
      logic idle_m = 1'b1;

      assign u_if.din       = din;
      assign u_if.din_valid = din_valid;

      uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (en),
         .bus   (u_if.slave),
         .tx    (tx_o),
         .busy  (busy_o),
         .done  (done_o)
      );

      // Reference: an accepted byte becomes a list of per-cycle line levels plus one done cycle.
      always @(negedge clk) begin
         exp_t e;
         logic [9+SB-1:0] frame;
         if (!pe_rst || !rst_n) begin
            q.delete();
            e = mk(1'b1, 1'b0, 1'b0);
         end else if (!pe_en) begin
            e = mk(last.tx, last.busy, 1'b0);
         end else begin
            if (idle_m && pe_valid) begin
               frame = {{SB{1'b1}}, pe_din, 1'b0};
               for (int b = 0; b < 9 + SB; b++)
                  for (int c = 0; c < CPB; c++)
                     q.push_back(mk(frame[b], 1'b1, 1'b0));
               q.push_back(mk(1'b1, 1'b0, 1'b1));
            end
            if (q.size() != 0) e = q.pop_front();
            else               e = mk(1'b1, 1'b0, 1'b0);
         end
         chk("tx",   SB, 8'(tx_o),   8'(e.tx));
         chk("busy", SB, 8'(busy_o), 8'(e.busy));
         chk("done", SB, 8'(done_o), 8'(e.done));
         last   = e;
         idle_m = !e.busy;
         if (rst_n) chk("din_ready", SB, 8'(u_if.din_ready), 8'(idle_m && en));
      end
   end

   task automatic step(int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Asynchronous reset pulse spanning one rising edge, with an immediate output check.
   task automatic pulse_reset();
      #1 rst_n = 1'b0;
      #1;
      chk("rst_tx",   1, 8'(g_dut[0].tx_o),   8'd1);
      chk("rst_busy", 1, 8'(g_dut[0].busy_o), 8'd0);
      chk("rst_tx",   2, 8'(g_dut[1].tx_o),   8'd1);
      chk("rst_busy", 2, 8'(g_dut[1].busy_o), 8'd0);
      @(negedge clk);
      #3 rst_n = 1'b1;
      step(1);
   endtask

   task automatic send_one(logic [7:0] b);
      din = b;
      din_valid = 1'b1;
      step(1);
      din_valid = 1'b0;
   endtask

   initial begin
      step(3);
      rst_n = 1'b1;
      en = 1'b1;
      step(2);

      // Single frame.
      send_one(8'hA5);
      step(50);

      // Valid held: second byte taken in the done cycle.
      din = 8'h00;
      din_valid = 1'b1;
      step(1);
      din = 8'hFF;
      step(42);
      din_valid = 1'b0;
      step(50);

      // Enable dropped for 3 cycles during data bit 2.
      send_one(8'h5A);
      step(12);
      en = 1'b0;
      step(3);
      en = 1'b1;
      step(50);

      // Reset during data bit 4, then a fresh byte.
      send_one(8'h81);
      step(21);
      pulse_reset();
      send_one(8'h3C);
      step(50);

      // din churn and stray valid pulses mid-frame.
      send_one(8'hC3);
      for (int i = 0; i < 40; i++) begin
         din = 8'($urandom);
         din_valid = (i % 7 == 3);
         step(1);
      end
      din_valid = 1'b0;
      step(20);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         en        = ($urandom_range(0, 9) != 0);
         din_valid = ($urandom_range(0, 3) == 0);
         din       = 8'($urandom);
         if ($urandom_range(0, 799) == 0) pulse_reset();
         else step(1);
      end

      en = 1'b1;
      din_valid = 1'b0;
      step(60);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per bit period; legal range 2..65535.
REQ-002 Parameter STOP_BITS, default 1, number of stop-bit periods; legal values 1 or 2.
REQ-003 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port en  input  1  global enable; low freezes all counters, state and tx.
REQ-006 Port din  input  8  byte to transmit; sampled only on the accept edge.
REQ-007 Port din_valid  input  1  requester asserts when din holds a byte to send.
REQ-008 Port din_ready  output  1  block can accept a byte this cycle.
REQ-009 Port tx  output  1  serial line, idle high, registered.
REQ-010 Port busy  output  1  high while a frame is in progress.
REQ-011 Port done  output  1  one-cycle pulse when a frame completes.

Function
REQ-012 States SHALL be IDLE, START, DATA, STOP; busy SHALL equal (state != IDLE).
REQ-013 din_ready SHALL equal (state == IDLE) && en, driven combinationally.
REQ-014 Accept SHALL occur on a rising edge with din_valid && din_ready: din latched into the shift register, baud counter cleared, state -> START.
REQ-015 Frame format: 8N1/8N2; tx = 0 in START, shift_reg[0] in DATA with LSB sent first, 1 in STOP and IDLE.
REQ-016 Baud counter SHALL count 0..CLKS_PER_BIT-1 on each enabled cycle; a bit period ends when it reaches CLKS_PER_BIT-1, and the counter then wraps to 0.
REQ-017 START SHALL last one bit period, then go to DATA with bit index 0.
REQ-018 DATA: at each bit-period end, shift register shifts right by 1 and 3-bit index increments; at end of index 7, state -> STOP and the index wraps to 0.
REQ-019 STOP SHALL last STOP_BITS bit periods, then state -> IDLE with done = 1 for exactly the first IDLE cycle.
REQ-020 Back-to-back: din_ready is high during the done cycle, so the next accept may occur there; minimum accept-to-accept spacing is (9+STOP_BITS)*CLKS_PER_BIT+1 cycles.
REQ-021 With en = 0, state, baud counter, bit index, shift register and tx SHALL hold, done SHALL hold 0, and no accept SHALL occur.
REQ-022 din_valid while busy SHALL be ignored and not queued; din changes after accept SHALL NOT affect the frame in flight.
REQ-023 Latency: tx falls in the cycle immediately after the accept edge.

Reset
REQ-024 rst_n low SHALL force, asynchronously: state = IDLE, tx = 1, busy = 0, done = 0, counters = 0, shift register = 0.
REQ-025 Reset mid-frame SHALL abort the frame with no done pulse; first accept is possible on the first enabled edge after rst_n rises.

Verification (CLKS_PER_BIT = 4 unless stated)
REQ-026 Single byte 0xA5, STOP_BITS = 1 -> tx 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; done pulses 40 cycles after the accept edge; busy high for 40 cycles.
REQ-027 din_valid held high with 0x00 then 0xFF -> second accept occurs in the done cycle; accepts are 41 cycles apart; tx shows 0x00 frame then 0xFF frame.
REQ-028 en low for 3 cycles during DATA bit 2 -> tx and counters hold; done is delayed to 43 cycles after accept; din_ready stays low.
REQ-029 rst_n pulsed low during DATA bit 4 -> tx = 1 and busy = 0 immediately with no clock; no done; a new byte 0x3C is accepted and sent correctly after release.
REQ-030 din toggled and din_valid pulsed during the frame -> transmitted bits unchanged, no extra frame; STOP_BITS = 2 -> stop high for 8 cycles, done at 44.
